rsa_byte_uart_tx: RTL and testbench
===================================

Name: rsa_byte_uart_tx

Overview:
- Downstream of the RSA pipeline CPU top-level.
- Captures each result byte the CPU presents on its read-data output, qualified by the CPU's read-enable strobe, into a small FIFO.
- Serializes the buffered bytes over a UART 8N1 line to the host PC.
- Raises a sticky done once the CPU's end flag has been seen and every captured byte has left the line.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per UART bit (50 MHz / 9600 baud); legal range 2..65535.
- FIFO_DEPTH, 16, byte entries in the capture FIFO; power of two, 2..256.

Ports:
- clk  input  1  system clock, single clock domain.
- reset  input  1  synchronous, active-high reset.
- byte_in  input  8  result byte from the CPU read-data output.
- byte_strobe  input  1  CPU read-enable level; its rising edge qualifies byte_in.
- end_flag  input  1  CPU end-of-program flag, level.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high while a frame is on the line (state != IDLE).
- fifo_full  output  1  capture FIFO holds FIFO_DEPTH entries.
- overflow  output  1  sticky; a strobe edge arrived while full with no pop.
- done  output  1  sticky; end seen, FIFO empty and serializer idle.

Behaviour:
- Reset values: tx=1, busy=0, fifo_full=0, overflow=0, done=0. Reset also clears the FIFO pointers/count, the edge-detect register, the end latch, and the bit and baud counters.
- Reset asserted mid-frame: tx=1 from the next cycle and the frame is abandoned.
- Strobe capture:
  - strobe_q <= byte_strobe every cycle.
  - push = byte_strobe & ~strobe_q; byte_in is sampled in that same cycle.
  - A level held high gives one push only.
- FIFO:
  - Write data becomes visible (count increments) on the cycle after the push.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push when full and no pop in the same cycle: byte dropped, overflow <= 1 until reset.
  - Push and pop in the same cycle when full: both performed, count unchanged, no overflow.
  - Push and pop when empty cannot happen: pop requires count > 0.
- Serializer states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If count>0: pop, load the shift register with the head byte, baud_cnt=0, go to START. tx drops low on the first cycle in START, i.e. one cycle after the pop decision.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first. Shift right after each bit. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if count>0, pop and go straight to START (back-to-back frames, no idle gap); else go to IDLE.
- Frame timing:
  - A frame occupies exactly 10*CLKS_PER_BIT cycles.
  - baud_cnt counts 0..CLKS_PER_BIT-1 and its compare is registered.
  - No extra cycle is added per bit.
- end/done:
  - end_seen <= 1 on any cycle with end_flag=1; sticky until reset.
  - done <= end_seen & (count==0) & (state==IDLE) & ~push. Once 1 it holds until reset.
  - Strobes arriving after done are still captured and transmitted; done stays 1.
- Width rules: baud_cnt is $clog2(CLKS_PER_BIT) bits, count is $clog2(FIFO_DEPTH)+1 bits, bit_idx is 3 bits.

Decomposition:
- Package rsa_io_pkg:
  - typedef enum logic [1:0] uart_state_t {IDLE, START, DATA, STOP}.
  - localparam UART_FRAME_BITS = 10.
  - localparam BYTE_W = 8.
- Sub-module rsa_byte_fifo (parameter FIFO_DEPTH):
  - Ports: clk, reset, push, wdata[7:0], pop, rdata[7:0], count, full, empty.
  - rdata is show-ahead: the head byte is valid whenever empty=0.
- The top block holds the edge detect, the end latch, and the serializer FSM.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
1. Reset mid-frame: tx=1 the cycle after reset, busy=0, done=0, overflow=0; after release, a new strobe transmits normally.
2. Single byte: one strobe edge with byte_in=0xA5 -> tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. busy high for exactly 40 cycles.
3. Held strobe: byte_strobe high for 20 cycles with byte_in=0x3C -> exactly one frame, FIFO count peaks at 1.
4. Back-to-back: strobe edges for 0x01, 0x02, 0x03 on cycles 0, 2 and 4 -> three contiguous frames, 120 cycles total, no idle gap between stop and start bits.
5. Overflow: 6 edges spaced 2 cycles apart while the first frame is in flight -> first byte popped; bytes 2..5 fill the FIFO; byte 6 dropped with overflow=1. Line output is 5 frames (bytes 1..5).
6. End/done: end_flag pulsed while 2 bytes are pending -> done stays 0 until the second stop bit ends and the FSM returns to IDLE, then done=1. A later strobe with 0x7E still transmits and done stays 1.

Source files
------------

// File: rtl/rsa_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rsa_io_pkg
//  Description : Shared types and constants for the RSA CPU host-side I/O.
//  Revision    : 1.0  initial release
// ============================================================================
package rsa_io_pkg;

   // Serializer states; a frame walks START -> DATA -> STOP.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   // Line bits per 8N1 frame: start + 8 data + stop.
   localparam int UART_FRAME_BITS = 10;

   // Width of one result byte.
   localparam int BYTE_W = 8;

endpackage
`default_nettype wire

// File: rtl/rsa_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rsa_byte_fifo
//  Description : Show-ahead byte FIFO buffering CPU result bytes for the UART.
//                A push into a full FIFO is accepted only if a pop happens in
//                the same cycle; otherwise the byte is dropped.
//  Revision    : 1.0  initial release
// ============================================================================
module rsa_byte_fifo
   import rsa_io_pkg::*;
#(
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  logic [BYTE_W-1:0]             wdata,
   input  logic                          pop,
   output logic [BYTE_W-1:0]             rdata,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          full,
   output logic                          empty
);

   localparam int c_AW = $clog2(FIFO_DEPTH);
   localparam logic [c_AW:0] c_DEPTH = (c_AW+1)'(FIFO_DEPTH);

   logic [BYTE_W-1:0] r_mem [FIFO_DEPTH];
   logic [c_AW-1:0]   r_wptr;
   logic [c_AW-1:0]   r_rptr;
   logic [c_AW:0]     r_count;
   logic              w_do_push;
   logic              w_do_pop;

   assign full      = (r_count == c_DEPTH);
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign rdata     = r_mem[r_rptr];
   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | w_do_pop);

   // Storage array; written only on accepted pushes, no reset required.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wptr] <= wdata;
      end
   end

   // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/rsa_byte_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : rsa_byte_uart_tx
//  Description : Captures CPU result bytes on rising edges of the read-enable
//                strobe, buffers them and sends them out as UART 8N1 frames.
//                Raises a sticky done once the CPU end flag has been seen and
//                the line has drained.
//  Revision    : 1.0  initial release
// ============================================================================
module rsa_byte_uart_tx
   import rsa_io_pkg::*;
#(
   parameter int CLKS_PER_BIT = 5208,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BYTE_W-1:0] byte_in,
   input  logic              byte_strobe,
   input  logic              end_flag,
   output logic              tx,
   output logic              busy,
   output logic              fifo_full,
   output logic              overflow,
   output logic              done
);

   localparam int c_BW = $clog2(CLKS_PER_BIT);
   // The bit-end flag is registered, so it is set while the counter sits on
   // the second-to-last value and is visible on the last cycle of the bit.
   localparam logic [c_BW-1:0] c_BAUD_PRELAST = c_BW'(CLKS_PER_BIT - 2);

   logic                        r_strobe_q;
   logic                        w_push;
   logic                        r_end_seen;
   logic                        r_done;
   logic                        r_overflow;
   logic                        r_tx;

   uart_state_t                 r_state;
   uart_state_t                 w_state_nx;
   logic [c_BW-1:0]             r_baud_cnt;
   logic [c_BW-1:0]             w_baud_nx;
   logic                        r_bit_end;
   logic                        w_bit_end_nx;
   logic [2:0]                  r_bit_idx;
   logic [2:0]                  w_bit_idx_nx;
   logic [BYTE_W-1:0]           r_shift;
   logic [BYTE_W-1:0]           w_shift_nx;
   logic                        w_tx_nx;
   logic                        w_pop;

   logic [BYTE_W-1:0]           w_rdata;
   logic [$clog2(FIFO_DEPTH):0] w_count;
   logic                        w_full;
   logic                        w_empty;

   assign w_push    = byte_strobe & ~r_strobe_q;
   assign tx        = r_tx;
   assign busy      = (r_state != IDLE);
   assign fifo_full = w_full;
   assign overflow  = r_overflow;
   assign done      = r_done;

   rsa_byte_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .wdata (byte_in),
      .pop   (w_pop),
      .rdata (w_rdata),
      .count (w_count),
      .full  (w_full),
      .empty (w_empty)
   );

   // Strobe edge detect, end latch and the sticky overflow/done flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_strobe_q <= 1'b0;
         r_end_seen <= 1'b0;
         r_overflow <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_strobe_q <= byte_strobe;
         if (end_flag) begin
            r_end_seen <= 1'b1;
         end
         if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end
         if (r_end_seen && (w_count == '0) && (r_state == IDLE) && !w_push) begin
            r_done <= 1'b1;
         end
      end
   end

   // Serializer state register, bit timer and registered line output.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_baud_cnt <= '0;
         r_bit_end  <= 1'b0;
         r_bit_idx  <= 3'd0;
         r_shift    <= '0;
         r_tx       <= 1'b1;
      end else begin
         r_state    <= w_state_nx;
         r_baud_cnt <= w_baud_nx;
         r_bit_end  <= w_bit_end_nx;
         r_bit_idx  <= w_bit_idx_nx;
         r_shift    <= w_shift_nx;
         r_tx       <= w_tx_nx;
      end
   end

   // Next-state logic: pop a byte from IDLE or at the end of STOP, walk bits.
   always_comb begin
      w_state_nx   = r_state;
      w_shift_nx   = r_shift;
      w_bit_idx_nx = r_bit_idx;
      w_pop        = 1'b0;
      if (r_bit_end) begin
         w_baud_nx    = '0;
         w_bit_end_nx = 1'b0;
      end else begin
         w_baud_nx    = r_baud_cnt + 1'b1;
         w_bit_end_nx = (r_baud_cnt == c_BAUD_PRELAST);
      end

      case (r_state)
         IDLE: begin
            w_baud_nx    = '0;
            w_bit_end_nx = 1'b0;
            if (!w_empty) begin
               w_pop      = 1'b1;
               w_shift_nx = w_rdata;
               w_state_nx = START;
            end
         end
         START: begin
            if (r_bit_end) begin
               w_bit_idx_nx = 3'd0;
               w_state_nx   = DATA;
            end
         end
         DATA: begin
            if (r_bit_end) begin
               w_shift_nx   = r_shift >> 1;
               w_bit_idx_nx = r_bit_idx + 3'd1;
               if (r_bit_idx == 3'd7) begin
                  w_state_nx = STOP;
               end
            end
         end
         STOP: begin
            if (r_bit_end) begin
               if (!w_empty) begin
                  w_pop      = 1'b1;
                  w_shift_nx = w_rdata;
                  w_state_nx = START;
               end else begin
                  w_state_nx = IDLE;
               end
            end
         end
         default: begin
            w_state_nx = IDLE;
         end
      endcase

      case (w_state_nx)
         START:   w_tx_nx = 1'b0;
         DATA:    w_tx_nx = w_shift_nx[0];
         default: w_tx_nx = 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_rsa_byte_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rsa_byte_uart_tx
//  Description : Scoreboard bench for rsa_byte_uart_tx (4 clocks/bit, depth 4).
//                Stimulus queues expected bytes; a line monitor decodes every
//                frame cycle by cycle and compares against the queue head.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rsa_byte_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] byte_in = 8'h00;
   logic       byte_strobe = 1'b0;
   logic       end_flag = 1'b0;
   logic       tx;
   logic       busy;
   logic       fifo_full;
   logic       overflow;
   logic       done;

   int         total = 0;
   int         bad = 0;
   logic [7:0] expq [$];
   logic       mon_en = 1'b0;
   logic       in_frame = 1'b0;
   int         busy_run = 0;
   int         last_run = 0;

   rsa_byte_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .byte_in     (byte_in),
      .byte_strobe (byte_strobe),
      .end_flag    (end_flag),
      .tx          (tx),
      .busy        (busy),
      .fifo_full   (fifo_full),
      .overflow    (overflow),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One strobe edge: high for one cycle, low for one cycle.
   task automatic pulse(input logic [7:0] b, input bit expect_tx);
      if (expect_tx) expq.push_back(b);
      byte_in     = b;
      byte_strobe = 1'b1;
      tick();
      byte_strobe = 1'b0;
      tick();
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((busy || in_frame || expq.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", {31'd0, n < budget}, 32'd1);
      repeat (4) @(negedge clk);
   endtask

   // Line monitor: every cycle of a frame must match start/data/stop of the
   // expected byte; also measures the length of each busy run.
   initial begin : monitor
      int         cyc;
      int         idx;
      logic [7:0] cur;
      logic [7:0] got;
      logic       ok;
      logic       have;
      logic       eb;
      cyc = 0; cur = 8'h00; got = 8'h00; ok = 1'b1; have = 1'b0;
      forever begin
         @(negedge clk);
         if (busy) busy_run++;
         else begin
            if (busy_run != 0) last_run = busy_run;
            busy_run = 0;
         end
         if (reset || !mon_en) begin
            in_frame = 1'b0;
         end else begin
            if (!in_frame && tx === 1'b0) begin
               in_frame = 1'b1;
               cyc = 0;
               ok = 1'b1;
               got = 8'h00;
               have = (expq.size() != 0);
               cur = have ? expq.pop_front() : 8'h00;
            end
            if (in_frame) begin
               idx = cyc / CPB;
               if (idx == 0) eb = 1'b0;
               else if (idx == 9) eb = 1'b1;
               else eb = cur[idx-1];
               if (idx >= 1 && idx <= 8 && (cyc % CPB) == CPB/2) got[idx-1] = tx;
               if (tx !== eb) ok = 1'b0;
               cyc++;
               if (cyc == FRAME) begin
                  in_frame = 1'b0;
                  total++;
                  if (!have || !ok) begin
                     bad++;
                     $display("FAIL frame: got %02h (expected_present=%0d clean=%0d) expected %02h",
                              got, have, ok, cur);
                  end
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic done_early;
      int   n;

      // Reset values
      repeat (3) tick();
      @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_full", fifo_full, 0);
      check("rst_overflow", overflow, 0);
      check("rst_done", done, 0);
      tick();
      reset = 1'b0;

      // 1. Reset mid-frame abandons the frame
      pulse(8'h00, 1'b0);
      repeat (10) tick();
      @(negedge clk);
      check("midframe_tx", tx, 0);
      check("midframe_busy", busy, 1);
      tick();
      reset = 1'b1;
      tick();
      @(negedge clk);
      check("rst_mid_tx", tx, 1);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_done", done, 0);
      check("rst_mid_overflow", overflow, 0);
      tick();
      reset = 1'b0;
      mon_en = 1'b1;
      pulse(8'hC3, 1'b1);
      wait_idle(200);

      // 2. Single byte 0xA5, start-bit latency and busy length
      expq.push_back(8'hA5);
      byte_in = 8'hA5;
      byte_strobe = 1'b1;
      tick();
      byte_strobe = 1'b0;
      @(negedge clk);
      check("pre_start_tx", tx, 1);
      @(negedge clk);
      check("start_latency_tx", tx, 0);
      wait_idle(200);
      check("single_busy_len", last_run, FRAME);

      // 3. Held strobe gives exactly one frame
      expq.push_back(8'h3C);
      byte_in = 8'h3C;
      byte_strobe = 1'b1;
      repeat (20) tick();
      byte_strobe = 1'b0;
      wait_idle(200);
      repeat (45) @(negedge clk);
      check("held_no_extra_busy", busy, 0);
      check("held_busy_len", last_run, FRAME);

      // 4. Back-to-back frames with no idle gap
      pulse(8'h01, 1'b1);
      pulse(8'h02, 1'b1);
      pulse(8'h03, 1'b1);
      wait_idle(400);
      check("b2b_busy_len", last_run, 3 * FRAME);

      // 5. Overflow: sixth byte dropped
      pulse(8'h11, 1'b1);
      pulse(8'h22, 1'b1);
      pulse(8'h33, 1'b1);
      pulse(8'h44, 1'b1);
      pulse(8'h55, 1'b1);
      @(negedge clk);
      check("ovf_full", fifo_full, 1);
      check("ovf_not_yet", overflow, 0);
      pulse(8'h66, 1'b0);
      @(negedge clk);
      check("ovf_set", overflow, 1);
      wait_idle(600);
      check("ovf_busy_len", last_run, 5 * FRAME);
      check("ovf_sticky", overflow, 1);
      check("no_done_without_end", done, 0);
      tick();
      reset = 1'b1;
      tick();
      tick();
      @(negedge clk);
      check("ovf_cleared", overflow, 0);
      tick();
      reset = 1'b0;

      // 6. end flag with two bytes pending
      pulse(8'h81, 1'b1);
      pulse(8'h42, 1'b1);
      end_flag = 1'b1;
      tick();
      end_flag = 1'b0;
      done_early = 1'b0;
      n = 0;
      @(negedge clk);
      while (busy && n < 300) begin
         if (done) done_early = 1'b1;
         @(negedge clk);
         n++;
      end
      check("done_busy_timeout", {31'd0, n < 300}, 32'd1);
      check("done_early", done_early, 0);
      check("done_first_idle", done, 0);
      @(negedge clk);
      check("done_set", done, 1);
      pulse(8'h7E, 1'b1);
      @(negedge clk);
      check("done_hold_push", done, 1);
      wait_idle(200);
      check("done_hold_end", done, 1);
      check("after_done_busy_len", last_run, FRAME);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
